// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands/control, EX-side registered outputs,
// hazard stall and halt status. bubble_cnt exists only with BUBBLE_CNT_EN.
interface id_ex_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc_inc;
    logic          id_r_format;
    logic          id_i_format;
    logic          id_mem_write;
    logic          id_mem_read;
    logic          id_reg_write;
    logic          id_halt;
    logic          flush;
    logic          ex_hold;

    logic          load_use_stall;
    logic          ex_valid;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_pc_inc;
    logic          ex_r_format;
    logic          ex_i_format;
    logic          ex_mem_write;
    logic          ex_mem_read;
    logic          ex_reg_write;
    logic          ex_halt;
    logic          halted;
`ifdef BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    // Driver side: ID stage and pipeline control
    modport master (
`ifdef BUBBLE_CNT_EN
        input  bubble_cnt,
`endif
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_a, id_b, id_imm, id_pc_inc,
               id_r_format, id_i_format, id_mem_write, id_mem_read,
               id_reg_write, id_halt, flush, ex_hold,
        input  load_use_stall, ex_valid, ex_rs, ex_rt, ex_rd,
               ex_a, ex_b, ex_imm, ex_pc_inc,
               ex_r_format, ex_i_format, ex_mem_write, ex_mem_read,
               ex_reg_write, ex_halt, halted
    );

    // Stage side: the ID/EX register itself
    modport slave (
`ifdef BUBBLE_CNT_EN
        output bubble_cnt,
`endif
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_a, id_b, id_imm, id_pc_inc,
               id_r_format, id_i_format, id_mem_write, id_mem_read,
               id_reg_write, id_halt, flush, ex_hold,
        output load_use_stall, ex_valid, ex_rs, ex_rt, ex_rd,
               ex_a, ex_b, ex_imm, ex_pc_inc,
               ex_r_format, ex_i_format, ex_mem_write, ex_mem_read,
               ex_reg_write, ex_halt, halted
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional feature macro: BUBBLE_CNT_EN adds a saturating 16-bit count of
// load-use bubbles on bus.bubble_cnt.
module id_ex_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic r_format;
        logic i_format;
        logic mem_write;
        logic mem_read;
        logic reg_write;
        logic halt;
    } ctrl_t;

    typedef enum logic [1:0] {UPD_LOAD, UPD_HOLD, UPD_BUBBLE} upd_e;

    logic          valid_q,  valid_d;
    ctrl_t         ctrl_q,   ctrl_d;
    ctrl_t         id_ctrl;
    logic [RW-1:0] rs_q,     rs_d;
    logic [RW-1:0] rt_q,     rt_d;
    logic [RW-1:0] rd_q,     rd_d;
    logic [DW-1:0] a_q,      a_d;
    logic [DW-1:0] b_q,      b_d;
    logic [DW-1:0] imm_q,    imm_d;
    logic [DW-1:0] pc_q,     pc_d;
    logic          halted_q, halted_d;
    logic          stall;
    upd_e          upd;

    // Load-use hazard: ID reads the register the load in EX is about to write
    always_comb begin
        stall = bus.id_valid & valid_q & ctrl_q.mem_read & ctrl_q.reg_write
              & ((bus.id_uses_rs & (bus.id_rs == rd_q))
               | (bus.id_uses_rt & (bus.id_rt == rd_q)))
              & ~halted_q;
    end

    // Update selection: flush, then hold, then halt/stall bubble, else load
    always_comb begin
        upd = UPD_LOAD;
        if (bus.flush) begin
            upd = UPD_BUBBLE;
        end else if (bus.ex_hold) begin
            upd = UPD_HOLD;
        end else if (halted_q || stall) begin
            upd = UPD_BUBBLE;
        end
    end

    // Decoded control from ID, zeroed for an invalid instruction
    always_comb begin
        id_ctrl = '0;
        if (bus.id_valid) begin
            id_ctrl.r_format  = bus.id_r_format;
            id_ctrl.i_format  = bus.id_i_format;
            id_ctrl.mem_write = bus.id_mem_write;
            id_ctrl.mem_read  = bus.id_mem_read;
            id_ctrl.reg_write = bus.id_reg_write;
            id_ctrl.halt      = bus.id_halt;
        end
    end

    // Next-state: a bubble kills valid/control but keeps datapath fields
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        case (upd)
            UPD_BUBBLE: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            UPD_LOAD: begin
                valid_d  = bus.id_valid;
                ctrl_d   = id_ctrl;
                rs_d     = bus.id_rs;
                rt_d     = bus.id_rt;
                rd_d     = bus.id_rd;
                a_d      = bus.id_a;
                b_d      = bus.id_b;
                imm_d    = bus.id_imm;
                pc_d     = bus.id_pc_inc;
                halted_d = halted_q | id_ctrl.halt;
            end
            default: ;
        endcase
    end

    // Pipeline register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

`ifdef BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic        bubble_ins;

    // Only a load-use bubble counts; flush, hold and halt bubbles do not
    always_comb begin
        bubble_ins = ~bus.flush & ~bus.ex_hold & ~halted_q & stall;
    end

    // Saturating bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (bubble_ins && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

    assign bus.load_use_stall = stall;
    assign bus.ex_valid       = valid_q;
    assign bus.ex_rs          = rs_q;
    assign bus.ex_rt          = rt_q;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_a           = a_q;
    assign bus.ex_b           = b_q;
    assign bus.ex_imm         = imm_q;
    assign bus.ex_pc_inc      = pc_q;
    assign bus.ex_r_format    = ctrl_q.r_format;
    assign bus.ex_i_format    = ctrl_q.i_format;
    assign bus.ex_mem_write   = ctrl_q.mem_write;
    assign bus.ex_mem_read    = ctrl_q.mem_read;
    assign bus.ex_reg_write   = ctrl_q.reg_write;
    assign bus.ex_halt        = ctrl_q.halt;
    assign bus.halted         = halted_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural reference model checked
// every negative edge, plus hand-computed expectations for directed scenarios.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if #(.DW(16), .RW(3)) bus ();

    id_ex_stage #(.DW(16), .RW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state (control bit order: r, i, mw, mr, rw, halt)
    localparam int C_R = 5, C_I = 4, C_MW = 3, C_MR = 2, C_RW = 1, C_H = 0;
    logic        m_valid = 1'b0;
    logic [5:0]  m_ctl   = '0;
    logic [2:0]  m_rs = '0, m_rt = '0, m_rd = '0;
    logic [15:0] m_a = '0, m_b = '0, m_imm = '0, m_pc = '0;
    logic        m_halted = 1'b0;
    int          m_cnt = 0;
    logic        m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_stall();
        logic hit;
        hit = (bus.id_uses_rs && bus.id_rs == m_rd) || (bus.id_uses_rt && bus.id_rt == m_rd);
        return bus.id_valid && m_valid && m_ctl[C_MR] && m_ctl[C_RW] && hit && !m_halted;
    endfunction

    // Reference model: per-edge behaviour from the priority rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_ctl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
            m_a = '0; m_b = '0; m_imm = '0; m_pc = '0; m_halted = 0; m_cnt = 0;
        end else begin
            m_st = model_stall();
            if (bus.flush) begin
                m_valid = 0; m_ctl = '0;
            end else if (bus.ex_hold) begin
                m_valid = m_valid;
            end else if (m_halted || m_st) begin
                m_valid = 0; m_ctl = '0;
                if (m_st && m_cnt < 65535) m_cnt = m_cnt + 1;
            end else begin
                m_valid = bus.id_valid;
                m_ctl   = bus.id_valid ? {bus.id_r_format, bus.id_i_format, bus.id_mem_write,
                                          bus.id_mem_read, bus.id_reg_write, bus.id_halt} : 6'b0;
                m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
                m_a = bus.id_a; m_b = bus.id_b; m_imm = bus.id_imm; m_pc = bus.id_pc_inc;
                if (bus.id_valid && bus.id_halt) m_halted = 1;
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        chk("ex_valid", bus.ex_valid, m_valid);
        chk("ex_rs", bus.ex_rs, m_rs);
        chk("ex_rt", bus.ex_rt, m_rt);
        chk("ex_rd", bus.ex_rd, m_rd);
        chk("ex_a", bus.ex_a, m_a);
        chk("ex_b", bus.ex_b, m_b);
        chk("ex_imm", bus.ex_imm, m_imm);
        chk("ex_pc_inc", bus.ex_pc_inc, m_pc);
        chk("ex_ctrl", {bus.ex_r_format, bus.ex_i_format, bus.ex_mem_write,
                        bus.ex_mem_read, bus.ex_reg_write, bus.ex_halt}, m_ctl);
        chk("halted", bus.halted, m_halted);
        chk("load_use_stall", bus.load_use_stall, model_stall());
`ifdef BUBBLE_CNT_EN
        chk("bubble_cnt", bus.bubble_cnt, m_cnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an ID instruction; b/imm/pc are derived from a
    task automatic id_set(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                          input logic [2:0] rd, input logic urs, input logic urt,
                          input logic mr, input logic rw, input logic hlt,
                          input logic [15:0] a);
        bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_uses_rs = urs; bus.id_uses_rt = urt;
        bus.id_a = a; bus.id_b = a ^ 16'hFFFF; bus.id_imm = a + 16'd1; bus.id_pc_inc = a + 16'd2;
        bus.id_r_format = ~mr; bus.id_i_format = mr; bus.id_mem_write = 1'b0;
        bus.id_mem_read = mr; bus.id_reg_write = rw; bus.id_halt = hlt;
    endtask

    task automatic chk_cnt(input int exp);
`ifdef BUBBLE_CNT_EN
        chk("bubble_cnt_lit", bus.bubble_cnt, exp);
`else
        if (exp < 0) $display("unexpected negative count");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.ex_hold = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step(); step();
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_halted", bus.halted, 0);
        rst = 1'b0;

        // Async reset while a valid instruction sits in EX
        id_set(1, 1, 2, 1, 0, 0, 0, 1, 0, 16'h0055);
        step();
        chk("pre_rst_valid", bus.ex_valid, 1);
        chk("pre_rst_rw", bus.ex_reg_write, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.ex_valid, 0);
        chk("async_rst_rw", bus.ex_reg_write, 0);
        chk("async_rst_halted", bus.halted, 0);
        step();
        rst = 1'b0;

        // Load-use on Rs
        id_set(1, 0, 0, 3, 0, 0, 1, 1, 0, 16'h00AA);
        step();
        chk("ld_rd", bus.ex_rd, 3);
        chk("ld_mr", bus.ex_mem_read, 1);
        id_set(1, 3, 1, 5, 1, 0, 0, 1, 0, 16'h0123);
        #1 chk("lu_stall", bus.load_use_stall, 1);
        step();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_mr", bus.ex_mem_read, 0);
        chk("lu_stall_drop", bus.load_use_stall, 0);
        step();
        chk("lu_load_valid", bus.ex_valid, 1);
        chk("lu_load_rs", bus.ex_rs, 3);
        chk("lu_load_a", bus.ex_a, 16'h0123);
        chk_cnt(1);

        // Rt matches but is not read: no stall
        id_set(1, 0, 0, 3, 0, 0, 1, 1, 0, 16'h0200);
        step();
        id_set(1, 0, 3, 6, 0, 0, 0, 1, 0, 16'h0300);
        #1 chk("nofalse_stall", bus.load_use_stall, 0);
        step();
        chk("nofalse_valid", bus.ex_valid, 1);
        chk("nofalse_rd", bus.ex_rd, 6);

        // Flush takes precedence over a load-use bubble
        id_set(1, 0, 0, 3, 0, 0, 1, 1, 0, 16'h0400);
        step();
        id_set(1, 3, 0, 4, 1, 0, 0, 1, 0, 16'h0500);
        bus.flush = 1'b1;
        #1 chk("flush_stall_comb", bus.load_use_stall, 1);
        step();
        bus.flush = 1'b0;
        chk("flush_valid", bus.ex_valid, 0);
        chk_cnt(1);
        step();

        // Rd = 0 is an ordinary register and still stalls
        id_set(1, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0600);
        step();
        id_set(1, 5, 0, 4, 1, 1, 0, 1, 0, 16'h0700);
        #1 chk("r0_stall", bus.load_use_stall, 1);
        step();
        chk_cnt(2);
        step();

        // Hold freezes the register while ID changes
        id_set(1, 1, 2, 4, 0, 0, 0, 1, 0, 16'h00AA);
        step();
        chk("hold_pre_a", bus.ex_a, 16'h00AA);
        bus.ex_hold = 1'b1;
        bus.id_a = 16'h1111; step(); chk("hold_a1", bus.ex_a, 16'h00AA);
        bus.id_a = 16'h1800; step(); chk("hold_a2", bus.ex_a, 16'h00AA);
        bus.id_a = 16'h2222; step(); chk("hold_a3", bus.ex_a, 16'h00AA);
        bus.ex_hold = 1'b0;
        step();
        chk("hold_release_a", bus.ex_a, 16'h2222);

        // Hold coinciding with a stall: stall persists, then one bubble
        id_set(1, 0, 0, 2, 0, 0, 1, 1, 0, 16'h0800);
        step();
        id_set(1, 2, 0, 3, 1, 0, 0, 1, 0, 16'h0900);
        bus.ex_hold = 1'b1;
        step();
        chk("hs_stall1", bus.load_use_stall, 1);
        chk("hs_valid", bus.ex_valid, 1);
        step();
        chk("hs_stall2", bus.load_use_stall, 1);
        bus.ex_hold = 1'b0;
        step();
        chk("hs_bubble", bus.ex_valid, 0);
        chk("hs_stall_drop", bus.load_use_stall, 0);
        chk_cnt(3);
        step();
        chk("hs_load", bus.ex_valid, 1);

        // Halt is sticky and forces bubbles
        id_set(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0A00);
        step();
        chk("halt_halted", bus.halted, 1);
        chk("halt_ex_halt", bus.ex_halt, 1);
        id_set(1, 1, 1, 7, 0, 0, 0, 1, 0, 16'h0B00);
        step();
        chk("halt_bubble_valid", bus.ex_valid, 0);
        chk("halt_bubble_rw", bus.ex_reg_write, 0);
        chk("halt_stays", bus.halted, 1);
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        bus.ex_hold = 1'b1; step(); bus.ex_hold = 1'b0;
        step();
        chk("halt_after_flush_hold", bus.halted, 1);
        chk("halt_still_bubble", bus.ex_valid, 0);

        rst = 1'b1;
        #1 chk("final_rst_halted", bus.halted, 0);
        chk_cnt(0);
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
